// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared AHB-lite encodings, response-FSM state type and the
// byte-enable decode used by the data SRAM port arbiter.
package dmem_arb_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_WR,
    ST_RD,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  // Sizes above word decode as a full word.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_en = 4'b1111;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_port.sv
// ahb_slave_port: one AHB-lite slave front end. Samples address phases,
// holds a losing request in PEND and sequences the response FSM.
// Optional DMEM_ARB_ERR_EN: faulting requests get a two-cycle ERROR response.
//
// Handshake: an address phase is accepted in a cycle where hready=1 and
// htrans[1]=1. hready=0 stretches the data phase; the master keeps its
// address/control stable and hwdata valid until it sees hready=1.
module ahb_slave_port
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       haddr,
  input  logic [2:0]        hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic              grant,
  input  logic [31:0]       data_read,
  output logic              hready,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              cand,
  output logic              pend,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_be,
  output logic              req_write,
  output resp_state_e       state
);

  resp_state_e       state_q, state_d;
  logic              req_present;
  logic              sample;
  logic              fault;
  logic [ADDR_W-1:0] pend_addr;
  logic [3:0]        pend_be;
  logic              pend_write;

  assign req_present = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign hready      = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                       (state_q == ST_RDATA) || (state_q == ST_ERR2);
  assign sample      = hready && req_present;

`ifdef DMEM_ARB_ERR_EN
  assign fault = sample && ((|haddr[31:ADDR_W+2]) || (hsize > HSIZE_WORD) ||
                            ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                            ((hsize == HSIZE_HALF) && haddr[0]));
  assign hresp = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  // Upper address bits simply wrap in this build.
  logic unused_haddr_hi;
  assign unused_haddr_hi = ^haddr[31:ADDR_W+2];
  assign fault = 1'b0;
  assign hresp = 1'b0;
`endif

  assign pend      = (state_q == ST_PEND);
  assign cand      = pend || (sample && !fault);
  assign req_addr  = pend ? pend_addr  : haddr[ADDR_W+1:2];
  assign req_be    = pend ? pend_be    : byte_en(hsize, haddr[1:0]);
  assign req_write = pend ? pend_write : hwrite;
  assign hrdata    = (state_q == ST_RDATA) ? data_read : 32'h0;
  assign state     = state_q;

  // Response FSM next state: fault, grant, or wait in PEND; else drain to IDLE.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_ERR1;
    end else if (grant) begin
      state_d = req_write ? ST_WR : ST_RD;
    end else if (cand) begin
      state_d = ST_PEND;
    end else begin
      case (state_q)
        ST_RD:   state_d = ST_RDATA;
        ST_ERR1: state_d = ST_ERR2;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Response FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture a freshly sampled request that lost arbitration this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_addr  <= '0;
      pend_be    <= 4'h0;
      pend_write <= 1'b0;
    end else if (sample && !fault && !grant) begin
      pend_addr  <= haddr[ADDR_W+1:2];
      pend_be    <= byte_en(hsize, haddr[1:0]);
      pend_write <= hwrite;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data SRAM port between the SPI loader and the
// core data interface. Round-robin on contention, PEND beats new requests,
// SPI_change locks out dmem. Optional DMEM_ARB_ERR_EN enables ERROR responses.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SPI_change,
  input  logic [31:0]       spi_haddr,
  input  logic [31:0]       spi_hwdata,
  input  logic [2:0]        spi_hsize,
  input  logic [1:0]        spi_htrans,
  input  logic              spi_hwrite,
  output logic [31:0]       spi_hrdata,
  output logic              spi_hready,
  output logic              spi_hresp,
  input  logic [31:0]       dmem_haddr,
  input  logic [31:0]       dmem_hwdata,
  input  logic [2:0]        dmem_hsize,
  input  logic [1:0]        dmem_htrans,
  input  logic              dmem_hwrite,
  output logic [31:0]       dmem_hrdata,
  output logic              dmem_hready,
  output logic              dmem_hresp,
  input  logic [31:0]       data_read,
  output logic [31:0]       data_write,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wben,
  output logic              data_rwn,
  output logic [2:0]        spi_state_dbg,
  output logic [2:0]        dmem_state_dbg
);

  logic              spi_cand, spi_pend, spi_req_write;
  logic              dmem_cand, dmem_pend, dmem_req_write;
  logic [ADDR_W-1:0] spi_req_addr, dmem_req_addr;
  logic [3:0]        spi_req_be, dmem_req_be;
  resp_state_e       spi_state, dmem_state;

  logic              dmem_cand_m, contested, pick_dmem;
  logic              grant_spi, grant_dmem;
  logic              rr_dmem;

  logic              acc_valid, acc_dmem, acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_be;

  ahb_slave_port #(.ADDR_W(ADDR_W)) u_spi (
    .clk(clk), .reset(reset),
    .haddr(spi_haddr), .hsize(spi_hsize), .htrans(spi_htrans), .hwrite(spi_hwrite),
    .grant(grant_spi), .data_read(data_read),
    .hready(spi_hready), .hresp(spi_hresp), .hrdata(spi_hrdata),
    .cand(spi_cand), .pend(spi_pend),
    .req_addr(spi_req_addr), .req_be(spi_req_be), .req_write(spi_req_write),
    .state(spi_state)
  );

  ahb_slave_port #(.ADDR_W(ADDR_W)) u_dmem (
    .clk(clk), .reset(reset),
    .haddr(dmem_haddr), .hsize(dmem_hsize), .htrans(dmem_htrans), .hwrite(dmem_hwrite),
    .grant(grant_dmem), .data_read(data_read),
    .hready(dmem_hready), .hresp(dmem_hresp), .hrdata(dmem_hrdata),
    .cand(dmem_cand), .pend(dmem_pend),
    .req_addr(dmem_req_addr), .req_be(dmem_req_be), .req_write(dmem_req_write),
    .state(dmem_state)
  );

  assign spi_state_dbg  = spi_state;
  assign dmem_state_dbg = dmem_state;

  // Pick at most one winner: PEND first, then the round-robin pointer.
  always_comb begin
    dmem_cand_m = dmem_cand && !SPI_change;
    contested   = spi_cand && dmem_cand_m;
    pick_dmem   = 1'b0;
    if (contested) begin
      if (spi_pend)       pick_dmem = 1'b0;
      else if (dmem_pend) pick_dmem = 1'b1;
      else                pick_dmem = rr_dmem;
    end else begin
      pick_dmem = dmem_cand_m;
    end
    grant_spi  = spi_cand && !pick_dmem;
    grant_dmem = dmem_cand_m && pick_dmem;
  end

  // Round-robin pointer: toggles after every contested grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rr_dmem <= 1'b0;
    else if (contested) rr_dmem <= ~rr_dmem;
  end

  // Register the granted request; it drives the SRAM for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_valid <= 1'b0;
      acc_dmem  <= 1'b0;
      acc_write <= 1'b0;
      acc_addr  <= '0;
      acc_be    <= 4'h0;
    end else begin
      acc_valid <= grant_spi || grant_dmem;
      if (grant_spi || grant_dmem) begin
        acc_dmem  <= grant_dmem;
        acc_write <= grant_dmem ? dmem_req_write : spi_req_write;
        acc_addr  <= grant_dmem ? dmem_req_addr  : spi_req_addr;
        acc_be    <= grant_dmem ? dmem_req_be    : spi_req_be;
      end
    end
  end

  // Write data comes from the owner's live data phase; address holds when idle.
  assign data_addr  = acc_addr;
  assign data_wben  = acc_valid ? acc_be : 4'h0;
  assign data_rwn   = !(acc_valid && acc_write);
  assign data_write = (acc_valid && acc_write) ? (acc_dmem ? dmem_hwdata : spi_hwdata) : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the SRAM port
// arbiter against a word-level memory model and an expected-access queue.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        SPI_change;
  logic [31:0] spi_haddr, spi_hwdata, spi_hrdata;
  logic [2:0]  spi_hsize;
  logic [1:0]  spi_htrans;
  logic        spi_hwrite, spi_hready, spi_hresp;
  logic [31:0] dmem_haddr, dmem_hwdata, dmem_hrdata;
  logic [2:0]  dmem_hsize;
  logic [1:0]  dmem_htrans;
  logic        dmem_hwrite, dmem_hready, dmem_hresp;
  logic [31:0] data_read, data_write;
  logic [13:0] data_addr;
  logic [3:0]  data_wben;
  logic        data_rwn;
  logic [2:0]  spi_state_dbg, dmem_state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [50:0] exp_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] sram[int];

  dmem_port_arbiter #(.ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .SPI_change(SPI_change),
    .spi_haddr(spi_haddr), .spi_hwdata(spi_hwdata), .spi_hsize(spi_hsize),
    .spi_htrans(spi_htrans), .spi_hwrite(spi_hwrite), .spi_hrdata(spi_hrdata),
    .spi_hready(spi_hready), .spi_hresp(spi_hresp),
    .dmem_haddr(dmem_haddr), .dmem_hwdata(dmem_hwdata), .dmem_hsize(dmem_hsize),
    .dmem_htrans(dmem_htrans), .dmem_hwrite(dmem_hwrite), .dmem_hrdata(dmem_hrdata),
    .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wben(data_wben), .data_rwn(data_rwn),
    .spi_state_dbg(spi_state_dbg), .dmem_state_dbg(dmem_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- SRAM model: read data one cycle after the access ----------------
  always @(posedge clk) begin
    logic [31:0] w;
    w = sram.exists(int'(data_addr)) ? sram[int'(data_addr)] : 32'h0;
    data_read <= w;
    if (!data_rwn) begin
      for (int b = 0; b < 4; b++)
        if (data_wben[b]) w[8*b +: 8] = data_write[8*b +: 8];
      sram[int'(data_addr)] = w;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [1:0] lo);
    if (sz == 3'd0) return 4'(1 << lo);
    if (sz == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [50:0] pack_acc(input logic [13:0] a, input logic [3:0] be,
                                           input logic rwn, input logic [31:0] d);
    return {a, be, rwn, rwn ? 32'h0 : d};
  endfunction

  task automatic ref_write(input int w, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = v;
  endtask

  // ---------------- scoreboard: every SRAM access must be the next expected one ----------------
  always @(negedge clk) begin
    logic [50:0] got, e;
    if (reset && data_wben != 4'h0) begin
      got = pack_acc(data_addr, data_wben, data_rwn, data_write);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sram_access: got unexpected access %h expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL sram_access: got %h expected %h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_addr(input int m, input logic [1:0] tr, input logic [31:0] a,
                            input logic [2:0] sz, input logic wr);
    if (m == 0) begin
      spi_htrans = tr; spi_haddr = a; spi_hsize = sz; spi_hwrite = wr;
    end else begin
      dmem_htrans = tr; dmem_haddr = a; dmem_hsize = sz; dmem_hwrite = wr;
    end
  endtask

  task automatic drive_wdata(input int m, input logic [31:0] d);
    if (m == 0) spi_hwdata = d;
    else        dmem_hwdata = d;
  endtask

  function automatic logic get_hready(input int m);
    return (m == 0) ? spi_hready : dmem_hready;
  endfunction

  function automatic logic [31:0] get_hrdata(input int m);
    return (m == 0) ? spi_hrdata : dmem_hrdata;
  endfunction

  // One uncontested transfer, started just after a rising edge with hready=1.
  // snap is the SRAM port seen in the first data-phase cycle.
  task automatic do_xfer(input int m, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output int waits,
                         output logic [50:0] snap);
    logic [3:0] be;
    be = exp_be(sz, a[1:0]);
    exp_q.push_back(pack_acc(a[15:2], be, !wr, wd));
    drive_addr(m, 2'b10, a, sz, wr);
    @(posedge clk); #1;
    drive_addr(m, 2'b00, 32'h0, 3'd0, 1'b0);
    drive_wdata(m, wd);
    waits = 0;
    @(negedge clk);
    snap = {data_addr, data_wben, data_rwn, data_write};
    while (!get_hready(m) && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = get_hrdata(m);
    if (wr) ref_write(int'(a[15:2]), be, wd);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0; SPI_change = 1'b0;
    drive_addr(0, 2'b00, 32'h0, 3'd0, 1'b0); drive_addr(1, 2'b00, 32'h0, 3'd0, 1'b0);
    spi_hwdata = 32'h0; dmem_hwdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({spi_hready, dmem_hready, spi_hresp, dmem_hresp} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_hs: got %b expected 1100", {spi_hready, dmem_hready, spi_hresp, dmem_hresp});
    end
    n_cmp++;
    if ({spi_hrdata, dmem_hrdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hrdata: got %h expected 0", {spi_hrdata, dmem_hrdata});
    end
    n_cmp++;
    if ({data_rwn, data_wben, data_addr, data_write} !== {1'b1, 4'h0, 14'h0, 32'h0}) begin
      n_fail++; $display("FAIL reset_sram: got %h expected %h", {data_rwn, data_wben, data_addr, data_write}, {1'b1, 4'h0, 14'h0, 32'h0});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({spi_hready, dmem_hready} !== 2'b11) begin
      n_fail++; $display("FAIL release_hready: got %b expected 11", {spi_hready, dmem_hready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; int w; logic [50:0] snap;
    do_xfer(0, 1'b1, 32'h0, 3'd2, 32'h01234567, rd, w, snap);
    n_cmp++;
    if (snap !== {14'h0, 4'b1111, 1'b0, 32'h01234567}) begin
      n_fail++; $display("FAIL word_write_port: got %h expected %h", snap, {14'h0, 4'b1111, 1'b0, 32'h01234567});
    end
    n_cmp++;
    if (w !== 0) begin n_fail++; $display("FAIL write_waits: got %0d expected 0", w); end
    do_xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, rd, w, snap);
    n_cmp++;
    if (w !== 1) begin n_fail++; $display("FAIL read_waits: got %0d expected 1", w); end
    n_cmp++;
    if (rd !== 32'h01234567) begin n_fail++; $display("FAIL read_data: got %h expected 01234567", rd); end
    n_cmp++;
    if ({snap[50:37], snap[32]} !== {14'h0, 1'b1}) begin
      n_fail++; $display("FAIL read_port: got %h expected %h", {snap[50:37], snap[32]}, {14'h0, 1'b1});
    end
  endtask

  task automatic test_byte_writes;
    logic [31:0] addrs[4] = '{32'h1, 32'h2, 32'h4003, 32'h4004};
    logic [13:0] waddr[4] = '{14'h0, 14'h0, 14'h1000, 14'h1001};
    logic [3:0]  wbe[4]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] rd; int w; logic [50:0] snap;
    for (int i = 0; i < 4; i++) begin
      do_xfer(0, 1'b1, addrs[i], 3'd0, $urandom, rd, w, snap);
      n_cmp++;
      if ({snap[50:37], snap[36:33], snap[32]} !== {waddr[i], wbe[i], 1'b0}) begin
        n_fail++; $display("FAIL byte_write %0d: got %h expected %h", i, {snap[50:37], snap[36:33], snap[32]}, {waddr[i], wbe[i], 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    exp_q.push_back(pack_acc(14'h8, 4'hF, 1'b0, d1));
    exp_q.push_back(pack_acc(14'h9, 4'hF, 1'b0, d2));
    exp_q.push_back(pack_acc(14'h8, 4'hF, 1'b1, 32'h0));
    drive_addr(0, 2'b10, 32'h20, 3'd2, 1'b1);
    @(posedge clk); #1;
    drive_addr(0, 2'b11, 32'h24, 3'd2, 1'b1); spi_hwdata = d1;
    @(negedge clk);
    n_cmp++;
    if (spi_hready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr1_hready: got %b expected 1", spi_hready); end
    @(posedge clk); #1;
    drive_addr(0, 2'b10, 32'h20, 3'd2, 1'b0); spi_hwdata = d2;
    @(negedge clk);
    n_cmp++;
    if (spi_hready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr2_hready: got %b expected 1", spi_hready); end
    @(posedge clk); #1;
    drive_addr(0, 2'b00, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (spi_hready !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_wait: got %b expected 0", spi_hready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({spi_hready, spi_hrdata} !== {1'b1, d1}) begin
      n_fail++; $display("FAIL b2b_rdata: got %h expected %h", {spi_hready, spi_hrdata}, {1'b1, d1});
    end
    ref_write(8, 4'hF, d1); ref_write(9, 4'hF, d2);
    @(posedge clk); #1;
  endtask

  task automatic test_contention;
    logic [31:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    // First contest: pointer at SPI.
    exp_q.push_back(pack_acc(14'h10, 4'hF, 1'b0, d[0]));
    exp_q.push_back(pack_acc(14'h11, 4'hF, 1'b0, d[1]));
    drive_addr(0, 2'b10, 32'h40, 3'd2, 1'b1);
    drive_addr(1, 2'b10, 32'h44, 3'd2, 1'b1);
    @(posedge clk); #1;
    drive_addr(0, 2'b00, 32'h0, 3'd0, 1'b0); drive_addr(1, 2'b00, 32'h0, 3'd0, 1'b0);
    spi_hwdata = d[0]; dmem_hwdata = d[1];
    @(negedge clk);
    n_cmp++;
    if ({spi_hready, dmem_hready} !== 2'b10) begin
      n_fail++; $display("FAIL contest1_first: got %b expected 10", {spi_hready, dmem_hready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (dmem_hready !== 1'b1) begin n_fail++; $display("FAIL contest1_pend_served: got %b expected 1", dmem_hready); end
    @(posedge clk); #1;
    // Second contest: pointer now at dmem.
    exp_q.push_back(pack_acc(14'h13, 4'hF, 1'b0, d[3]));
    exp_q.push_back(pack_acc(14'h12, 4'hF, 1'b0, d[2]));
    drive_addr(0, 2'b10, 32'h48, 3'd2, 1'b1);
    drive_addr(1, 2'b10, 32'h4C, 3'd2, 1'b1);
    @(posedge clk); #1;
    drive_addr(0, 2'b00, 32'h0, 3'd0, 1'b0); drive_addr(1, 2'b00, 32'h0, 3'd0, 1'b0);
    spi_hwdata = d[2]; dmem_hwdata = d[3];
    @(negedge clk);
    n_cmp++;
    if ({spi_hready, dmem_hready} !== 2'b01) begin
      n_fail++; $display("FAIL contest2_first: got %b expected 01", {spi_hready, dmem_hready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (spi_hready !== 1'b1) begin n_fail++; $display("FAIL contest2_pend_served: got %b expected 1", spi_hready); end
    for (int i = 0; i < 4; i++) ref_write(16 + i, 4'hF, d[i]);
    @(posedge clk); #1;
  endtask

  task automatic test_spi_change;
    logic [31:0] rd; int w; logic [50:0] snap;
    SPI_change = 1'b1;
    drive_addr(1, 2'b10, 32'h44, 3'd2, 1'b0);
    @(posedge clk); #1;
    drive_addr(1, 2'b00, 32'h0, 3'd0, 1'b0);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          do_xfer(0, 1'b1, 32'h80 + 32'(4 * i), 3'd2, $urandom, rd, w, snap);
          n_cmp++;
          if (w !== 0) begin n_fail++; $display("FAIL spi_under_lock_waits: got %0d expected 0", w); end
        end
      end
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          n_cmp++;
          if (dmem_hready !== 1'b0) begin n_fail++; $display("FAIL lock_hold %0d: got %b expected 0", i, dmem_hready); end
        end
      end
    join
    @(posedge clk); #1;
    SPI_change = 1'b0;
    exp_q.push_back(pack_acc(14'h11, 4'hF, 1'b1, 32'h0));
    @(negedge clk);
    n_cmp++;
    if (dmem_hready !== 1'b0) begin n_fail++; $display("FAIL unlock_pend: got %b expected 0", dmem_hready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (dmem_hready !== 1'b0) begin n_fail++; $display("FAIL unlock_rd: got %b expected 0", dmem_hready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({dmem_hready, dmem_hrdata} !== {1'b1, ref_mem[17]}) begin
      n_fail++; $display("FAIL unlock_rdata: got %h expected %h", {dmem_hready, dmem_hrdata}, {1'b1, ref_mem[17]});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_high_addr;
`ifdef DMEM_ARB_ERR_EN
    drive_addr(0, 2'b10, 32'h00010000, 3'd2, 1'b0);
    @(posedge clk); #1;
    drive_addr(0, 2'b00, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({spi_hresp, spi_hready, data_rwn} !== 3'b101) begin
      n_fail++; $display("FAIL err1: got %b expected 101", {spi_hresp, spi_hready, data_rwn});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({spi_hresp, spi_hready, data_rwn} !== 3'b111) begin
      n_fail++; $display("FAIL err2: got %b expected 111", {spi_hresp, spi_hready, data_rwn});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (spi_hresp !== 1'b0) begin n_fail++; $display("FAIL err_done: got %b expected 0", spi_hresp); end
    @(posedge clk); #1;
`else
    logic [31:0] rd; int w; logic [50:0] snap;
    do_xfer(0, 1'b0, 32'h00010000, 3'd2, 32'h0, rd, w, snap);
    n_cmp++;
    if ({snap[50:37], rd, spi_hresp} !== {14'h0, ref_mem[0], 1'b0}) begin
      n_fail++; $display("FAIL addr_wrap: got %h expected %h", {snap[50:37], rd, spi_hresp}, {14'h0, ref_mem[0], 1'b0});
    end
`endif
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d; int w, m, wr, sz, lo; logic [50:0] snap;
    for (int i = 0; i < 8; i++) do_xfer(i % 2, 1'b1, 32'hC0 + 32'(4 * i), 3'd2, $urandom, rd, w, snap);
    for (int i = 0; i < 40; i++) begin
      m  = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      sz = $urandom_range(0, 2);
      lo = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      a  = 32'hC0 + 32'(4 * $urandom_range(0, 7)) + 32'(lo);
      d  = $urandom;
      do_xfer(m, wr[0], a, sz[2:0], d, rd, w, snap);
      n_cmp++;
      if (w !== (wr[0] ? 0 : 1)) begin n_fail++; $display("FAIL rand_waits %0d: got %0d expected %0d", i, w, wr[0] ? 0 : 1); end
      if (!wr[0]) begin
        n_cmp++;
        if (rd !== ref_mem[int'(a[15:2])]) begin
          n_fail++; $display("FAIL rand_rdata %0d: got %h expected %h", i, rd, ref_mem[int'(a[15:2])]);
        end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] rd; int w; logic [50:0] snap;
    drive_addr(1, 2'b10, 32'hC4, 3'd2, 1'b0);
    @(posedge clk); #1;
    drive_addr(1, 2'b00, 32'h0, 3'd0, 1'b0);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({dmem_hready, data_rwn, data_wben, dmem_hrdata} !== {1'b1, 1'b1, 4'h0, 32'h0}) begin
      n_fail++; $display("FAIL midflight_reset: got %h expected %h", {dmem_hready, data_rwn, data_wben, dmem_hrdata}, {1'b1, 1'b1, 4'h0, 32'h0});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_xfer(1, 1'b0, 32'hC8, 3'd2, 32'h0, rd, w, snap);
    n_cmp++;
    if ({w, rd} !== {32'd1, ref_mem[50]}) begin
      n_fail++; $display("FAIL after_reset_read: got %h expected %h", {w, rd}, {32'd1, ref_mem[50]});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_write_read;
    test_byte_writes;
    test_back_to_back;
    test_contention;
    test_spi_change;
    test_high_addr;
    test_random;
    test_reset_midflight;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_accesses: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
